irq_priority_controller: RTL



---
 rtl/irq_priority_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/irq_priority_controller.sv
`default_nettype none
//==============================================================================
// Module   : irq_priority_controller
// Purpose  : Multi-source interrupt controller feeding the core's interrupt
//            request input. Rising edges on the peripheral lines are latched
//            as pending events. The lowest-index pending and enabled source is
//            presented to the core together with its mcause value. That
//            request is held until the core returns from the handler (mret).
//            On return, the serviced pending bit is cleared and arbitration
//            runs again after one idle cycle.
//
// Ports    : clk_i          - system clock (rising edge)
//            rst_i          - asynchronous active-high reset
//            irq_i          - peripheral interrupt lines (rising-edge events)
//            mie_i          - per-source enable mask
//            irq_ret_i      - single-cycle return-from-handler pulse
//            irq_o          - interrupt request to the core
//            irq_id_o       - index of the source being serviced
//            irq_cause_o    - mcause value of the serviced source
//            irq_pending_o  - raw pending register (CSR readback / debug)
//
// Options  : IRQ_PRIORITY_CTRL_SYNC_EN - when defined, irq_i passes through a
//            2-flop synchronizer before edge detection. This raises the
//            event-to-request latency from 2 to 4 clock edges.
//
// Revision : 1.0 - initial release
//==============================================================================
module irq_priority_controller #(
   parameter int IRQ_NUM = 16,
   parameter int ID_W    = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_i,
   input  logic [IRQ_NUM-1:0] mie_i,
   input  logic               irq_ret_i,
   output logic               irq_o,
   output logic [ID_W-1:0]    irq_id_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_pending_o
);

   localparam logic [31:0] C_CAUSE_BASE = 32'h8000_0010;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_irq;
   logic [ID_W-1:0]    r_id;
   logic [31:0]        r_cause;
   logic [IRQ_NUM-1:0] r_pending;
   logic [IRQ_NUM-1:0] r_irq_q;

   logic [IRQ_NUM-1:0] w_irq_src;
   logic [IRQ_NUM-1:0] w_edge;
   logic [IRQ_NUM-1:0] w_elig;
   logic [IRQ_NUM-1:0] w_clr;
   logic               w_any;
   logic [ID_W-1:0]    w_win_id;
   logic [31:0]        w_win_cause;

   //---------------------------------------------------------------------------
   // Input conditioning
   //---------------------------------------------------------------------------
`ifdef IRQ_PRIORITY_CTRL_SYNC_EN
   logic [IRQ_NUM-1:0] r_sync1;
   logic [IRQ_NUM-1:0] r_sync2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_src = r_sync2;
`else
   assign w_irq_src = irq_i;
`endif

   // History resets to 0, so a line already high when reset is released
   // produces exactly one event.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_irq_q <= '0;
      end else begin
         r_irq_q <= w_irq_src;
      end
   end

   assign w_edge = w_irq_src & ~r_irq_q;

   //---------------------------------------------------------------------------
   // Arbitration: fixed priority, the lowest eligible index wins. The loop
   // scans downward so that the last assignment belongs to the lowest index.
   //---------------------------------------------------------------------------
   assign w_elig = r_pending & mie_i;
   assign w_any  = |w_elig;

   always_comb begin
      w_win_id = '0;
      for (int k = IRQ_NUM - 1; k >= 0; k--) begin
         if (w_elig[k]) begin
            w_win_id = ID_W'(k);
         end
      end
   end

   assign w_win_cause = C_CAUSE_BASE + {{(32 - ID_W){1'b0}}, w_win_id};

   //---------------------------------------------------------------------------
   // Pending register: a clear happens only on return while serving, and only
   // for the latched id. The new edge is OR-ed in after the clear, so a new
   // event that coincides with the return is kept.
   //---------------------------------------------------------------------------
   always_comb begin
      w_clr = '0;
      if ((r_state == ST_SERVE) && irq_ret_i) begin
         for (int k = 0; k < IRQ_NUM; k++) begin
            w_clr[k] = (r_id == ID_W'(k));
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_edge;
      end
   end

   //---------------------------------------------------------------------------
   // Request FSM. The outputs are registered. Leaving SERVE always passes
   // through IDLE, so irq_o is low for at least one cycle between requests.
   // The id is not cleared on return, so software can still read which
   // source was last serviced.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_irq   <= 1'b0;
         r_id    <= '0;
         r_cause <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_irq <= 1'b0;
               if (w_any) begin
                  r_state <= ST_SERVE;
                  r_irq   <= 1'b1;
                  r_id    <= w_win_id;
                  r_cause <= w_win_cause;
               end
            end
            ST_SERVE: begin
               // The mask and new edges are deliberately ignored here:
               // an active request is never preempted or withdrawn.
               if (irq_ret_i) begin
                  r_state <= ST_IDLE;
                  r_irq   <= 1'b0;
                  r_cause <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_irq   <= 1'b0;
               r_cause <= '0;
            end
         endcase
      end
   end

   assign irq_o         = r_irq;
   assign irq_id_o      = r_id;
   assign irq_cause_o   = r_cause;
   assign irq_pending_o = r_pending;

endmodule
`default_nettype wire
